// File: rtl/cover_toggle_collector.sv
// Sticky toggle-cover hit collector: records first-time hits per point and streams each
// newly hit point once as an absolute cover index over a valid/ready handshake.
module cover_toggle_collector #(
    parameter int unsigned COVER_POINTS = 8,
    parameter int unsigned COVER_INDEX  = 0,
    parameter int unsigned COVER_TOTAL  = 38253,
    localparam int unsigned CW = $clog2(COVER_POINTS + 1),
    localparam int unsigned IW = (COVER_POINTS > 1) ? $clog2(COVER_POINTS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [COVER_POINTS-1:0] valid,
    input  logic                    clear,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [63:0]             out_index,
    output logic [CW-1:0]           hit_count,
    output logic                    all_hit
);

    if (COVER_POINTS < 1 || COVER_POINTS > 1024 ||
        COVER_INDEX + COVER_POINTS > COVER_TOTAL) begin : g_bad_cfg
        $error("cover_toggle_collector: invalid cover-point configuration");
    end

    typedef enum logic {StEmpty, StHold} state_e;

    state_e                  state_q, state_d;
    logic [COVER_POINTS-1:0] hit_q, hit_d;
    logic [COVER_POINTS-1:0] pending_q, pending_d;
    logic [63:0]             index_q, index_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    all_hit_q, all_hit_d;

    logic [COVER_POINTS-1:0] new_bits;
    logic [CW-1:0]           new_cnt;
    logic [IW-1:0]           low_idx;
    logic                    low_found;
    logic                    load;

    always_comb begin
        new_bits = valid & ~hit_q;
        new_cnt  = '0;
        for (int i = 0; i < int'(COVER_POINTS); i++) begin
            new_cnt = new_cnt + CW'(new_bits[i]);
        end

        // Priority pick of the lowest registered pending bit.
        low_found = 1'b0;
        low_idx   = '0;
        for (int i = int'(COVER_POINTS) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_found = 1'b1;
                low_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        hit_d     = hit_q | new_bits;
        pending_d = pending_q | new_bits;
        count_d   = count_q + new_cnt;
        load      = low_found && ((state_q == StEmpty) || out_ready);

        if (load) begin
            pending_d[low_idx] = 1'b0;
            index_d            = 64'(COVER_INDEX) + 64'(low_idx);
            state_d            = StHold;
        end else if (state_q == StHold && out_ready) begin
            state_d = StEmpty;
        end

        // Clear wins over capture and load; any held index is dropped.
        if (clear) begin
            hit_d     = '0;
            pending_d = '0;
            count_d   = '0;
            state_d   = StEmpty;
        end

        all_hit_d = (count_d == CW'(COVER_POINTS));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StEmpty;
            hit_q     <= '0;
            pending_q <= '0;
            index_q   <= '0;
            count_q   <= '0;
            all_hit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hit_q     <= hit_d;
            pending_q <= pending_d;
            index_q   <= index_d;
            count_q   <= count_d;
            all_hit_q <= all_hit_d;
        end
    end

    assign out_valid = (state_q == StHold);
    assign out_index = index_q;
    assign hit_count = count_q;
    assign all_hit   = all_hit_q;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Scoreboarded bench for cover_toggle_collector: stimulus pushes expected indices, a monitor
// pops and compares on every accepted handshake.
module tb_cover_toggle_collector;

    localparam int unsigned N   = 8;
    localparam int unsigned IDX = 100;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] valid;
    logic         clear;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_index;
    logic [3:0]   hit_count;
    logic         all_hit;

    int checks = 0;
    int errors = 0;
    longint unsigned exp_q[$];

    cover_toggle_collector #(
        .COVER_POINTS(N),
        .COVER_INDEX (IDX),
        .COVER_TOTAL (38253)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .valid    (valid),
        .clear    (clear),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_index(out_index),
        .hit_count(hit_count),
        .all_hit  (all_hit)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: a handshake seen mid-cycle completes at the next rising edge.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream_unexpected: got index %0d expected no output at %0t",
                         out_index, $time);
            end else begin
                chk("stream_index", out_index, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_range(input int unsigned mask);
        for (int i = 0; i < int'(N); i++) begin
            if (mask[i]) exp_q.push_back(longint'(IDX + i));
        end
    endtask

    initial begin
        reset     = 1'b1;
        valid     = '0;
        clear     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_all_hit", all_hit, 0);
        chk("rst_out_index", out_index, 0);
        reset = 1'b0;
        tick();

        // Two points in one cycle: emitted at t+2 and t+3.
        do_clear();
        valid = 8'h05;
        push_range(32'h05);
        tick();
        valid = '0;
        chk("lat_t1_no_valid", out_valid, 0);
        tick();
        chk("lat_t2_valid", out_valid, 1);
        chk("lat_t2_index", out_index, IDX);
        tick();
        chk("lat_t3_index", out_index, IDX + 2);
        tick();
        chk("lat_done", out_valid, 0);
        chk("lat_count", hit_count, 2);
        chk("lat_all_hit", all_hit, 0);

        // Held toggle is emitted and counted once.
        do_clear();
        valid = 8'h01;
        push_range(32'h01);
        repeat (10) tick();
        valid = '0;
        repeat (3) tick();
        chk("held_count", hit_count, 1);
        chk("held_no_valid", out_valid, 0);

        // Back-pressure holds the index stable.
        do_clear();
        out_ready = 1'b0;
        valid = 8'h0A;
        push_range(32'h0A);
        tick();
        valid = '0;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_index", out_index, IDX + 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_next_index", out_index, IDX + 3);
        tick();
        chk("bp_done", out_valid, 0);
        chk("bp_count", hit_count, 2);

        // Clear while holding with more pending discards everything.
        do_clear();
        out_ready = 1'b0;
        valid = 8'h0A;
        tick();
        valid = '0;
        tick();
        tick();
        chk("clr_pre_valid", out_valid, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_valid", out_valid, 0);
        chk("clr_count", hit_count, 0);
        out_ready = 1'b1;
        valid = 8'h02;
        push_range(32'h02);
        tick();
        valid = '0;
        tick();
        chk("clr_reemit_valid", out_valid, 1);
        chk("clr_reemit_index", out_index, IDX + 1);
        tick();
        chk("clr_no_stale", out_valid, 0);

        // All points at once, continuous ready: one index per cycle.
        do_clear();
        valid = 8'hFF;
        push_range(32'hFF);
        tick();
        valid = '0;
        chk("all_count", hit_count, N);
        chk("all_hit", all_hit, 1);
        for (int k = 0; k < int'(N); k++) begin
            tick();
            chk("burst_valid", out_valid, 1);
            chk("burst_index", out_index, IDX + k);
        end
        tick();
        chk("burst_done", out_valid, 0);

        // Toggling ready: every index exactly once, in order.
        do_clear();
        valid = 8'hFF;
        push_range(32'hFF);
        for (int k = 0; k < 30; k++) begin
            out_ready = (k % 3) != 1;
            tick();
            valid = '0;
        end
        out_ready = 1'b1;
        repeat (4) tick();
        chk("toggle_all_drained", exp_q.size(), 0);
        chk("toggle_done", out_valid, 0);

        // Reset mid-drain drops out_valid without waiting for a clock.
        do_clear();
        valid = 8'hFF;
        push_range(32'hFF);
        tick();
        valid = '0;
        tick();
        tick();
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_mid_count", hit_count, 0);
        chk("rst_mid_idle", out_valid, 0);
        valid = 8'h01;
        push_range(32'h01);
        tick();
        valid = '0;
        tick();
        chk("rst_reemit_valid", out_valid, 1);
        chk("rst_reemit_index", out_index, IDX);
        tick();
        tick();

        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
